cpu_clock_sched: RTL
====================

// Module: cpu_clock_sched
// PURPOSE
//  Scheduler for the Z80 clock enable. Picks one enable pair from the clock block
//  (3.58 / 5.37 / 10.7 MHz) from a requested turbo speed.
//  Switches between sources without glitches, only at safe phase boundaries.
//  Forces 3.58 MHz around I/O cycles and inserts the turbo M1 wait state.
//  Sits between the clock block and the T80 core's clock-enable and WAIT_n inputs.
// PARAMETERS
//  IO_SLOW_CYCLES  4  cpu_ce_p pulses held at 3.58 MHz after iorq_n deasserts (1..15)
//  M1_WAIT         1  wait periods inserted per M1 cycle in turbo (0..3; 0 disables)
// PORTS
//  clk21m      in   1  21.477 MHz system clock
//  reset       in   1  asynchronous, active-high
//  ce_10m7_p   in   1  source enables from the clock block; one-cycle pulses,
//  ce_10m7_n   in   1    each _p is followed by its _n before the next _p
//  ce_5m39_p   in   1
//  ce_5m39_n   in   1
//  ce_3m58_p   in   1
//  ce_3m58_n   in   1
//  speed_req   in   2  0 = 3.58 MHz, 1 = 5.37 MHz, 2 = 10.7 MHz, 3 = treated as 0
//  iorq_n      in   1  CPU IORQ_n
//  mreq_n      in   1  CPU MREQ_n
//  m1_n        in   1  CPU M1_n
//  ext_wait    in   1  active-high wait request from peripherals, passed through
//  cpu_ce_p    out  1  CPU rising-phase enable
//  cpu_ce_n    out  1  CPU falling-phase enable
//  cpu_wait_n  out  1  WAIT_n to CPU
//  speed_cur   out  2  source currently driving cpu_ce_*
//  switching   out  1  high while in DRAIN or ALIGN
// BEHAVIOUR
//  Reset values:
//   - cpu_ce_p = cpu_ce_n = 0; cpu_wait_n = 1; speed_cur = 0.
//   - State = ALIGN, target 0. io_slow = 0; M1 counter = 0 and armed.
//  Effective speed: eff = io_slow ? 0 : (speed_req == 3 ? 0 : speed_req).
//  State machine, registered on clk21m:
//   - RUN: cpu_ce_p/n = the _p/_n pair selected by speed_cur (combinational AND).
//     If eff != speed_cur, go to DRAIN.
//   - DRAIN: keep forwarding the speed_cur pair.
//     On the cycle the selected _n pulse is forwarded, latch target = eff and go to ALIGN.
//     Switch only after a complete p/n period.
//   - ALIGN: cpu_ce_p/n forced to 0.
//     On the first target _p pulse: forward it that same cycle, set speed_cur = target, go to RUN.
//     eff changing during ALIGN does not retarget; the new value is handled from RUN.
//  Guarantees:
//   - No _n without a preceding _p.
//   - No two _p without an _n between them.
//   - Minimum spacing between consecutive cpu_ce_p is 2 clk21m cycles.
//  I/O slowdown:
//   - Falling edge of iorq_n (registered compare) while eff != 0 sets io_slow = 1.
//   - io_slow stays set while iorq_n = 0.
//   - After iorq_n rises, count IO_SLOW_CYCLES cpu_ce_p pulses, then clear io_slow.
//   - A new iorq_n falling edge during the countdown reloads the count.
//  M1 wait:
//   - Applies only when speed_cur != 0 and M1_WAIT != 0.
//   - Trigger: the first cpu_ce_p with m1_n = 0, mreq_n = 0 and the M1 logic armed.
//   - On trigger, load the counter with M1_WAIT and disarm.
//   - Counter decrements on each following cpu_ce_p.
//   - The M1 logic re-arms when m1_n = 1.
//  cpu_wait_n = ~((counter != 0) | ext_wait), registered; asserts the cycle after the trigger.
//  Simultaneous events:
//   - Speed change during an active M1 wait: the counter keeps counting on the new source.
//   - iorq_n falling and speed_req change on the same cycle: io_slow has priority (eff = 0).
//   - Reset mid-switch: returns to the reset state immediately (asynchronous).
// TESTING
//  T1 reset, speed_req = 0:
//     release -> first cpu_ce_p coincides with ce_3m58_p; then p/n every 6 cycles, 3 cycles apart.
//  T2 speed_req 0 -> 2 mid-period:
//     no pulse until the 3.58 _n; switching high in between;
//     next cpu_ce_p = first ce_10m7_p after it; speed_cur = 2.
//  T3 speed 2, iorq_n low for 8 cpu clocks:
//     eff drops to 0 via DRAIN/ALIGN;
//     speed_cur returns to 2 after 4 cpu_ce_p pulses past iorq_n rising.
//  T4 speed 1, M1_WAIT = 1, M1 fetch:
//     cpu_wait_n low for exactly one cpu_ce_p period; no wait at speed 0.
//  T5 ext_wait = 1 for 10 cycles at speed 2:
//     cpu_wait_n low for 10 cycles (1-cycle delay); cpu_ce_* keep toggling.
//  T6 reset asserted during ALIGN:
//     all outputs are reset values within the same cycle; recovery as in T1.

Source files
------------

// File: rtl/cpu_clock_sched.sv
// Z80 clock-enable scheduler: selects a 3.58/5.37/10.7 MHz enable pair, switches glitch-free,
// slows to 3.58 MHz around I/O cycles and inserts the turbo M1 wait state.
module cpu_clock_sched #(
    parameter int IO_SLOW_CYCLES = 4,
    parameter int M1_WAIT        = 1
) (
    input  logic       clk21m,
    input  logic       reset,
    input  logic       ce_10m7_p,
    input  logic       ce_10m7_n,
    input  logic       ce_5m39_p,
    input  logic       ce_5m39_n,
    input  logic       ce_3m58_p,
    input  logic       ce_3m58_n,
    input  logic [1:0] speed_req,
    input  logic       iorq_n,
    input  logic       mreq_n,
    input  logic       m1_n,
    input  logic       ext_wait,
    output logic       cpu_ce_p,
    output logic       cpu_ce_n,
    output logic       cpu_wait_n,
    output logic [1:0] speed_cur,
    output logic       switching
);
    // state | meaning
    // RUN   | forwarding the speed_cur pair, watching for a speed change
    // DRAIN | still forwarding speed_cur until its _n completes the period
    // ALIGN | outputs quiet until the first _p of the latched target

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ALIGN} state_t;

    localparam logic [3:0] IO_LOAD = 4'(IO_SLOW_CYCLES);
    localparam logic [1:0] M1_LOAD = 2'(M1_WAIT);

    state_t     state;
    logic [1:0] target;
    logic [1:0] req_spd;
    logic [1:0] eff;
    logic       cur_p, cur_n, tgt_p;
    logic       iorq_q;
    logic       io_fall, io_set;
    logic       io_slow;
    logic [3:0] io_cnt;
    logic [1:0] m1_cnt, m1_nxt;
    logic       m1_armed, m1_trig;

    always_comb begin
        req_spd = (speed_req == 2'd3) ? 2'd0 : speed_req;
        io_fall = iorq_q & ~iorq_n;
        io_set  = io_fall & (req_spd != 2'd0);
        // a same-cycle I/O start already forces 3.58 MHz so DRAIN never latches the turbo speed
        eff     = (io_slow | io_set) ? 2'd0 : req_spd;
    end

    always_comb begin
        cur_p = ce_3m58_p;
        cur_n = ce_3m58_n;
        case (speed_cur)
            2'd1: begin cur_p = ce_5m39_p; cur_n = ce_5m39_n; end
            2'd2: begin cur_p = ce_10m7_p; cur_n = ce_10m7_n; end
            default: ;
        endcase
        tgt_p = ce_3m58_p;
        case (target)
            2'd1: tgt_p = ce_5m39_p;
            2'd2: tgt_p = ce_10m7_p;
            default: ;
        endcase
    end

    always_comb begin
        cpu_ce_p = 1'b0;
        cpu_ce_n = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN, ST_DRAIN: begin
                    cpu_ce_p = cur_p;
                    cpu_ce_n = cur_n;
                end
                ST_ALIGN: cpu_ce_p = tgt_p;
                default: ;
            endcase
        end
    end

    assign switching = (state != ST_RUN);

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state     <= ST_ALIGN;
            target    <= 2'd0;
            speed_cur <= 2'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (eff != speed_cur) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (cur_n) begin
                        target <= eff;
                        state  <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (tgt_p) begin
                        speed_cur <= target;
                        state     <= ST_RUN;
                    end
                end
                default: state <= ST_ALIGN;
            endcase
        end
    end

    assign m1_trig = cpu_ce_p & ~m1_n & ~mreq_n & m1_armed &
                     (speed_cur != 2'd0) & (M1_LOAD != 2'd0);

    always_comb begin
        m1_nxt = m1_cnt;
        if (m1_trig)
            m1_nxt = M1_LOAD;
        else if (cpu_ce_p && m1_cnt != 2'd0)
            m1_nxt = m1_cnt - 2'd1;
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            iorq_q     <= 1'b1;
            io_slow    <= 1'b0;
            io_cnt     <= 4'd0;
            m1_cnt     <= 2'd0;
            m1_armed   <= 1'b1;
            cpu_wait_n <= 1'b1;
        end else begin
            iorq_q <= iorq_n;
            // countdown only runs once IORQ_n is back high; a new I/O cycle restarts it
            if (io_fall && (io_slow || req_spd != 2'd0)) begin
                io_slow <= 1'b1;
                io_cnt  <= IO_LOAD;
            end else if (io_slow && iorq_n && cpu_ce_p) begin
                if (io_cnt <= 4'd1) begin
                    io_slow <= 1'b0;
                    io_cnt  <= 4'd0;
                end else begin
                    io_cnt <= io_cnt - 4'd1;
                end
            end
            if (m1_trig)
                m1_armed <= 1'b0;
            else if (m1_n)
                m1_armed <= 1'b1;
            m1_cnt     <= m1_nxt;
            cpu_wait_n <= ~((m1_nxt != 2'd0) | ext_wait);
        end
    end
endmodule
